// File: rtl/mem_responder.sv
// Main-memory responder for cache line fills (fixed-latency read bursts) and writebacks.
// Optional build macro MEM_CRITICAL_WORD_FIRST_EN: read bursts start at rd_addr[5:3] and wrap.
module mem_responder #(
  parameter int MEM_WIDTH  = 64,
  parameter int BLOCK_SIZE = 64,
  parameter int AWIDTH     = 32,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rd_en,
  input  logic [AWIDTH-1:0]    i_rd_addr,
  input  logic                 i_wr_en,
  input  logic [AWIDTH-1:0]    i_wr_addr,
  input  logic [MEM_WIDTH-1:0] i_wr_data,
  input  logic                 i_wr_data_valid,
  output logic                 o_busy,
  output logic [MEM_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_data_valid,
  output logic [2:0]           o_rd_beat,
  output logic                 o_rd_last,
  output logic                 o_wr_done
);
  localparam int BEATS = BLOCK_SIZE * 8 / MEM_WIDTH;
  localparam int OFFW  = $clog2(BLOCK_SIZE);
  localparam int LW    = $clog2(MEM_LINES);
  localparam int CW    = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_ACK} state_t;

  state_t                 r_state, w_state_nxt;
  logic [LW-1:0]          r_line;
  logic [2:0]             r_beat;
  logic [2:0]             r_cnt;
  logic [CW-1:0]          r_lat;
  logic                   r_busy, r_rd_data_valid, r_rd_last, r_wr_done;
  logic [MEM_WIDTH-1:0]   r_rd_data;
  logic [2:0]             r_rd_beat;
  logic [MEM_WIDTH-1:0]   r_mem [MEM_LINES*BEATS];

  logic                   w_acc_wr, w_acc_rd, w_rd_issue, w_wr_beat, w_rd_last_nxt;
  logic [LW+2:0]          w_idx;
  logic [2:0]             w_rd_start;
  logic                   w_unused;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam int BYTEW = $clog2(MEM_WIDTH / 8);
  assign w_rd_start = i_rd_addr[BYTEW +: 3];
`else
  assign w_rd_start = 3'd0;
`endif

  // Offset bits and line bits above the array depth are deliberately dropped.
  assign w_unused = ^{i_rd_addr, i_wr_addr};
  assign w_idx    = {r_line, r_beat};

  always_comb begin
    w_state_nxt = r_state;
    w_acc_wr    = 1'b0;
    w_acc_rd    = 1'b0;
    w_rd_issue  = 1'b0;
    w_wr_beat   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_wr_en) begin
          w_acc_wr    = 1'b1;
          w_state_nxt = WR_BURST;
        end else if (i_rd_en) begin
          w_acc_rd    = 1'b1;
          w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_lat == '0) begin
          w_rd_issue  = 1'b1;
          w_state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        if (r_rd_last) w_state_nxt = IDLE;
        else           w_rd_issue  = 1'b1;
      end
      WR_BURST: begin
        if (i_wr_data_valid) begin
          w_wr_beat = 1'b1;
          if (r_cnt == 3'(BEATS - 1)) w_state_nxt = WR_ACK;
        end
      end
      WR_ACK:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_rd_last_nxt = w_rd_issue && (r_cnt == 3'(BEATS - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_line          <= '0;
      r_beat          <= '0;
      r_cnt           <= '0;
      r_lat           <= '0;
      r_busy          <= 1'b0;
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
      r_rd_beat       <= '0;
      r_rd_last       <= 1'b0;
      r_wr_done       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_busy          <= (w_state_nxt != IDLE);
      r_wr_done       <= (w_state_nxt == WR_ACK);
      r_rd_data_valid <= w_rd_issue;
      r_rd_last       <= w_rd_last_nxt;
      if (w_acc_wr) begin
        r_line <= i_wr_addr[OFFW +: LW];
        r_beat <= '0;
        r_cnt  <= '0;
      end
      if (w_acc_rd) begin
        r_line <= i_rd_addr[OFFW +: LW];
        r_beat <= w_rd_start;
        r_cnt  <= '0;
        r_lat  <= CW'(LATENCY - 1);
      end
      if (r_state == RD_WAIT && r_lat != '0) r_lat <= r_lat - 1'b1;
      // r_beat is the next beat to move; r_cnt counts beats moved (sets rd_last / ends writes).
      if (w_rd_issue) begin
        r_rd_data <= r_mem[w_idx];
        r_rd_beat <= r_beat;
        r_beat    <= r_beat + 1'b1;
        r_cnt     <= r_cnt + 1'b1;
      end
      if (w_wr_beat) begin
        r_beat <= r_beat + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Storage is intentionally not reset; committed beats survive a reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_beat) r_mem[w_idx] <= i_wr_data;
  end

  assign o_busy          = r_busy;
  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_data_valid;
  assign o_rd_beat       = r_rd_beat;
  assign o_rd_last       = r_rd_last;
  assign o_wr_done       = r_wr_done;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven write/read pairs, corner sequences,
// then random traffic against a line-array reference model.
module tb_mem_responder;
  localparam int LAT       = 4;
  localparam int MEM_LINES = 1024;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk, rst;
  logic        rd_en, wr_en, wr_data_valid;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] wr_data;
  logic        busy, rd_data_valid, rd_last, wr_done;
  logic [63:0] rd_data;
  logic [2:0]  rd_beat;

  mem_responder dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_data_valid(wr_data_valid),
    .o_busy(busy), .o_rd_data(rd_data), .o_rd_data_valid(rd_data_valid),
    .o_rd_beat(rd_beat), .o_rd_last(rd_last), .o_wr_done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [63:0] model [int];
  logic [63:0] wbuf [8];
  logic [31:0] wlist [$];

  typedef struct {
    logic [31:0] waddr;
    logic [7:0]  gaps;
    logic [63:0] base;
    logic [31:0] raddr;
    logic [2:0]  exp_start;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int key(input logic [31:0] a, input int b);
    return int'((a >> 6) % 32'(MEM_LINES)) * 8 + b;
  endfunction

  function automatic logic [2:0] start_of(input logic [31:0] a);
    return CWF ? a[5:3] : 3'd0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Writes wbuf[0..7] to the line of addr; gaps[b]=1 inserts an idle cycle before beat b.
  task automatic wr_line(input logic [31:0] addr, input logic [7:0] gaps);
    wait_idle();
    wr_en = 1'b1; wr_addr = addr;
    @(negedge clk);
    wr_en = 1'b0; wr_addr = $urandom;
    chk("wr_busy", 64'(busy), 64'd1);
    for (int b = 0; b < 8; b++) begin
      if (gaps[b]) begin
        wr_data_valid = 1'b0; wr_data = {$urandom, $urandom};
        @(negedge clk);
        chk("wr_gap_done", 64'(wr_done), 64'd0);
      end
      wr_data_valid = 1'b1; wr_data = wbuf[b];
      @(negedge clk);
      chk("wr_done", 64'(wr_done), 64'(b == 7));
      model[key(addr, b)] = wbuf[b];
    end
    wr_data_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse", 64'(wr_done), 64'd0);
    chk("wr_busy_end", 64'(busy), 64'd0);
  endtask

  // Reads the line of addr expecting a burst starting at beat st; optional reset at cycle rst_at.
  task automatic read_line(input logic [31:0] addr, input logic [2:0] st, input int rst_at);
    int b;
    logic exp_v;
    wait_idle();
    rd_en = 1'b1; rd_addr = addr;
    @(negedge clk);
    rd_en = 1'b0; rd_addr = $urandom;
    for (int k = 1; k <= LAT + 9; k++) begin
      @(negedge clk);
      exp_v = (k >= LAT) && (k <= LAT + 7);
      chk("rd_valid", 64'(rd_data_valid), 64'(exp_v));
      chk("rd_last", 64'(rd_last), 64'(k == LAT + 7));
      chk("rd_busy", 64'(busy), 64'(k <= LAT + 7));
      if (exp_v) begin
        b = (int'(st) + k - LAT) % 8;
        chk("rd_beat", 64'(rd_beat), 64'(b));
        chk("rd_data", rd_data, model[key(addr, b)]);
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(rd_data_valid), 64'd0);
        chk("rst_last", 64'(rd_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", rd_data, 64'd0);
        chk("rst_beat", 64'(rd_beat), 64'd0);
        chk("rst_wr_done", 64'(wr_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("post_rst_valid", 64'(rd_data_valid), 64'd0);
          chk("post_rst_busy", 64'(busy), 64'd0);
        end
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; wr_data_valid = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(rd_data_valid), 64'd0);
    chk("reset_last", 64'(rd_last), 64'd0);
    chk("reset_wr_done", 64'(wr_done), 64'd0);
    chk("reset_data", rd_data, 64'd0);
    chk("reset_beat", 64'(rd_beat), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // waddr, gaps, data base (beat i = base*(i+1)), raddr, expected first beat
    vecs[0] = '{32'h0000_0040, 8'h00, 64'h1111,                32'h0000_0040, 3'd0};
    vecs[1] = '{32'h0000_0080, 8'hA6, 64'h0123_4567_0000_0011, 32'h0000_0080, 3'd0};
    vecs[2] = '{32'h0001_0040, 8'h00, 64'h5A5A_0000_0000_0101, 32'h0000_0040, 3'd0};
    vecs[3] = '{32'h0000_0068, 8'h81, 64'h0000_0BAD_0000_0707, 32'h0000_0068, CWF ? 3'd5 : 3'd0};
    vecs[4] = '{32'hFFFF_FFC0, 8'h10, 64'h7777_0000_0000_0003, 32'h0003_FFC8, CWF ? 3'd1 : 3'd0};
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = vecs[v].base * 64'(i + 1);
      wr_line(vecs[v].waddr, vecs[v].gaps);
      read_line(vecs[v].raddr, vecs[v].exp_start, -1);
    end

    // Simultaneous read and write to the same line: write first, read sees new data.
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    rd_en = 1'b1; rd_addr = 32'h80;
    wr_line(32'h80, 8'h00);
    read_line(32'h80, 3'd0, -1);

    // Beats offered while idle must not land in the array.
    wr_data_valid = 1'b1;
    repeat (3) begin
      wr_data = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    wr_data_valid = 1'b0;
    read_line(32'h40, 3'd0, -1);

    // Reset during beat 3 of a burst, then a fresh read still works and data survives.
    read_line(32'h40, 3'd0, LAT + 3);
    read_line(32'h40, 3'd0, -1);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      if (wlist.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = $urandom;
        for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
        wr_line(a, 8'($urandom_range(0, 255) & $urandom_range(0, 255)));
        wlist.push_back(a);
      end else begin
        a = wlist[$urandom_range(0, wlist.size() - 1)];
        a[5:0] = 6'($urandom);
        read_line(a, start_of(a), -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory-side responder for the cache's line-fill and writeback interface.
- Accepts one line request at a time: a read (fill) or a write (writeback).
  - Reads: returns the line as a burst of 64-bit beats after a fixed latency.
  - Writes: absorbs a beat burst into an internal array, then acknowledges.
- Sits between the cache data/control block and the system. Serves as the simulation memory model and as the reference behaviour for a real memory controller.

Parameters:
MEM_WIDTH, 64, beat width in bits
BLOCK_SIZE, 64, line size in bytes (BEATS = BLOCK_SIZE*8/MEM_WIDTH = 8)
AWIDTH, 32, byte address width
MEM_LINES, 1024, lines held in the array (power of two; 64 KiB default)
LATENCY, 4, cycles from read acceptance to first data beat (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
rd_en  in  1  line read request, held by cache until accepted
rd_addr  in  AWIDTH  read byte address; line = rd_addr[AWIDTH-1:6]
wr_en  in  1  line write request, held by cache until accepted
wr_addr  in  AWIDTH  write byte address; bits [5:0] ignored
wr_data  in  MEM_WIDTH  writeback beat from cache
wr_data_valid  in  1  wr_data holds a beat
busy  out  1  1 = request in progress; a request is accepted only on an edge where busy=0
rd_data  out  MEM_WIDTH  fill beat to cache
rd_data_valid  out  1  rd_data valid this cycle
rd_beat  out  3  beat index of the current rd_data
rd_last  out  1  final beat of the read burst
wr_done  out  1  one-cycle pulse: writeback fully committed

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, rd_data_valid=0, rd_last=0, wr_done=0, rd_data=0, rd_beat=0, counters=0. Array contents are not reset.
- Reset mid-burst aborts the burst with no further beats. Write beats already committed remain in the array.
- Array index = {line[log2(MEM_LINES)-1:0], beat}. Upper line bits are ignored, so addresses wrap modulo MEM_LINES.
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_ACK. busy=1 in every state except IDLE, registered.
- IDLE:
  - wr_en=1 -> latch line, beat=0, go to WR_BURST.
  - Else rd_en=1 -> latch line and start beat, load the latency counter, go to RD_WAIT.
  - Simultaneous rd_en and wr_en: write wins. The read stays pending (cache holds rd_en) and is accepted after wr_done.
- RD_WAIT: count LATENCY-1 further cycles. The first beat is driven LATENCY cycles after the accept edge.
- RD_BURST:
  - 8 consecutive cycles with rd_data_valid=1; no stalls.
  - rd_beat increments mod 8 from the start beat (0 unless the optional feature is enabled).
  - rd_last=1 on the 8th beat; next state IDLE.
  - busy drops the cycle after rd_last.
- WR_BURST:
  - Each cycle with wr_data_valid=1 writes wr_data to array[{line, beat}] and increments beat.
  - Gaps (valid=0) are allowed and hold the beat count.
  - After the 8th accepted beat -> WR_ACK.
- WR_ACK: wr_done=1 for exactly one cycle, then IDLE.
- A read issued after wr_done to the same line returns the newly written data (no stale beats).
- In IDLE, wr_data_valid is ignored.
- rd_en or wr_en changes while busy are ignored. Request fields are latched only at acceptance.

Optional Feature:
MEM_CRITICAL_WORD_FIRST_EN
- Defined: read bursts start at beat rd_addr[5:3] and wrap (e.g. 5,6,7,0,1,2,3,4). rd_beat reports the true beat index, and rd_last marks the 8th beat delivered.
- Undefined: read bursts always return beats 0..7 in order; rd_addr[5:0] is ignored.
- Writes always start at beat 0 in both builds.

Test Plan:
- Reset, then write line 0x0000_0040 with beats 0x1111..0x8888 back-to-back -> wr_done pulses exactly 1 cycle after the 8th beat; busy=0 the following cycle.
- Read 0x0000_0040 (LATENCY=4), accept at edge N -> rd_data_valid at N+4..N+11, data 0x1111..0x8888, rd_beat 0..7, rd_last only at N+11.
- rd_en and wr_en asserted together (rd 0x80, wr 0x80 with new data) -> write performed first, then the read returns the new data.
- Write with wr_data_valid gaps (valid 1,0,0,1,...) -> exactly 8 beats committed in order; wr_done only after the 8th valid beat.
- Assert rst during beat 3 of a read burst -> all outputs 0 immediately; no further beats; a new read is accepted after rst deasserts.
- With MEM_CRITICAL_WORD_FIRST_EN, read 0x0000_0068 -> rd_beat sequence 5,6,7,0,1,2,3,4 with matching data; rd_last on beat 4. Without the macro -> sequence 0..7.
